hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates the stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers, including the D/E register's flush and ~stallE enable.
- Detects load-use and branch-compare hazards.
- Owns a multi-cycle divide sequencer: an FSM plus counter that freezes F/D/E while the iterative divider runs and bubbles E/M.

Parameters:
- DIV_CYCLES, 32, number of cycles the divider needs after its start pulse (legal range 2..63).
- CNT_W, 6, width of the divide down-counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- rsD, rtD  in  5  source register numbers in Decode.
- rsE, rtE  in  5  source register numbers in Execute.
- writeregE, writeregM, writeregW  in  5  destination register numbers per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- MemtoRegE, MemtoRegM  in  1  load indicators.
- branchD, jrD  in  1  Decode instruction compares or reads registers.
- pcsrcD  in  1  Decode branch/jump taken.
- divE  in  1  Execute holds a DIV/DIVU.
- stallF, stallD, stallE  out  1  hold the PC, F/D and D/E registers.
- flushD, flushE, flushM  out  1  bubble the F/D, D/E and E/M registers.
- forwardAD, forwardBD  out  1  M-stage bypass for the Decode compare operands.
- forwardAE, forwardBE  out  2  Execute bypass: 00 regfile, 01 W, 10 M.
- div_start  out  1  one-cycle divider start pulse.
- div_busy  out  1  divider sequence in progress.

Behaviour:
- Reset (reset==0 at an edge): FSM goes to IDLE and the counter clears to 0.
- While reset is low, every output is forced to 0 except flushD=flushE=flushM=1.
- Execute forwarding for operand A (B is identical using rtE):
  - forwardAE = 10 if rsE!=0 && RegWriteM && rsE==writeregM.
  - Otherwise 01 if rsE!=0 && RegWriteW && rsE==writeregW.
  - Otherwise 00. M has priority over W.
- Decode forwarding: forwardAD = rsD!=0 && RegWriteM && rsD==writeregM. forwardBD is the same using rtD.
- Load-use stall: lwstall = MemtoRegE && rtE!=0 && (rtE==rsD || rtE==rtD).
- Branch stall: brstall = (branchD||jrD) && ((RegWriteE && writeregE!=0 && writeregE∈{rsD,rtD}) || (MemtoRegM && writeregM!=0 && writeregM∈{rsD,rtD})).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if divE, then divstall=1 and div_start=1; load counter with DIV_CYCLES-1; next state BUSY.
  - BUSY: divstall=1; counter decrements each cycle; on counter==0, next state DONE. BUSY lasts exactly DIV_CYCLES cycles.
  - DONE: no divstall; the divide leaves E at the end of this cycle; next state IDLE. DONE blocks retrigger on the same instruction.
  - A div entering E in the cycle right after DONE is detected normally in IDLE.
  - div_busy=1 in BUSY and in the IDLE trigger cycle.
- Stall and flush combination:
  - stallF = stallD = lwstall | brstall | divstall.
  - stallE = divstall.
  - flushE = (lwstall | brstall) & ~divstall. While E is frozen it is never flushed.
  - flushM = divstall, which prevents the stalled E instruction from being duplicated into M.
  - flushD = pcsrcD & ~stallD.
- Timing: DIV/DIVU in E sees stallE=1 for DIV_CYCLES+1 consecutive cycles, then advances.
- Mid-sequence reset: aborts immediately to IDLE; no div_start is issued on the reset edge.

Decomposition:
- Shared package (mips_defs): forwarding select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; FSM state encoding (IDLE=0, BUSY=1, DONE=2); default DIV_CYCLES.
- One natural sub-module: div_seq, containing the FSM, counter, div_start, div_busy and divstall. Hazard and forwarding logic stays in hazard_ctrl.

Test Plan:
- Forwarding: rsE=5, RegWriteM=1, writeregM=5, RegWriteW=1, writeregW=5 -> forwardAE=10. With writeregM=6 -> 01. With rsE=0 -> 00.
- Load-use: MemtoRegE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1, stallE=0 for exactly one cycle. rtE=0 -> no stall.
- Branch: branchD=1, rsD=3, RegWriteE=1, writeregE=3 -> stall one cycle. Next cycle MemtoRegM=1, writeregM=3 -> stall again. Then clear, with forwardAD=1 when RegWriteM && writeregM==3.
- Divide with DIV_CYCLES=4: divE held -> div_start single pulse, stallE=flushM=1 for 5 cycles, then one DONE cycle with no stall, no second start. Back-to-back div immediately restarts.
- Reset mid-BUSY (after 2 cycles): reset=0 -> all stalls 0, flushes 1, FSM IDLE. Release with divE=1 -> fresh div_start, full 5-cycle stall.
- Taken branch pcsrcD=1 with lwstall=1 -> flushD=0. Without stall -> flushD=1.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS pipeline control path: bypass selects,
// divide-sequencer state encoding and the default divider latency.
package mips_defs;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int DEF_DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  // Execute-stage bypass select; the younger M result wins over W.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic       regWriteM,
    input logic [4:0] writeregM,
    input logic       regWriteW,
    input logic [4:0] writeregW
  );
    if (src != 5'd0 && regWriteM && src == writeregM) return FWD_M;
    if (src != 5'd0 && regWriteW && src == writeregW) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Divide sequencer: holds the DIV in Execute while the iterative divider runs,
// then lets it leave through a DONE cycle that cannot retrigger.
module div_seq
  import mips_defs::*;
#(
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic divE,
  output logic divStart,
  output logic divBusy,
  output logic divStall
);

  divState_t        state;
  logic [CNT_W-1:0] cnt;
  logic             trigger;

  assign trigger = (state == IDLE) && divE;

  // NOTE: state and counter use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (divE) begin
          state <= BUSY;
          cnt   <= CNT_W'(DIV_CYCLES - 1);
        end
        BUSY: if (cnt == '0) state <= DONE;
              else           cnt   <= cnt - CNT_W'(1);
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The trigger cycle must already stall, so these decode the current state
  // together with divE rather than waiting a cycle for a registered copy.
  assign divStart = reset && trigger;
  assign divBusy  = reset && (trigger || state == BUSY);
  assign divStall = divBusy;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: bypass selects,
// load-use / branch-compare stalls, flushes and the divide freeze.
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       pcsrcD,
  input  logic       divE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       div_start,
  output logic       div_busy
);

  logic lwstall;
  logic brstall;
  logic divstall;
  logic hazStall;
  logic hitE;
  logic hitM;

  div_seq #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_seq (
    .clk      (clk),
    .reset    (reset),
    .divE     (divE),
    .divStart (div_start),
    .divBusy  (div_busy),
    .divStall (divstall)
  );

  assign lwstall = MemtoRegE && rtE != 5'd0 && (rtE == rsD || rtE == rtD);

  // Decode compares need final register values: an E-stage writer cannot be
  // bypassed yet, and an M-stage load has no data until W.
  assign hitE    = RegWriteE && writeregE != 5'd0 && (writeregE == rsD || writeregE == rtD);
  assign hitM    = MemtoRegM && writeregM != 5'd0 && (writeregM == rsD || writeregM == rtD);
  assign brstall = (branchD || jrD) && (hitE || hitM);

  // divstall is already gated by reset inside the sequencer.
  assign hazStall = reset && (lwstall || brstall);

  assign stallF = hazStall || divstall;
  assign stallD = stallF;
  assign stallE = divstall;

  // A frozen E register must not be flushed, and the held E instruction is
  // replaced by a bubble in M so it is not issued twice.
  assign flushE = !reset || (hazStall && !divstall);
  assign flushM = !reset || divstall;
  assign flushD = !reset || (pcsrcD && !stallD);

  assign forwardAD = reset && rsD != 5'd0 && RegWriteM && rsD == writeregM;
  assign forwardBD = reset && rtD != 5'd0 && RegWriteM && rtD == writeregM;
  assign forwardAE = reset ? fwdSel(rsE, RegWriteM, writeregM, RegWriteW, writeregW) : FWD_RF;
  assign forwardBE = reset ? fwdSel(rtE, RegWriteM, writeregM, RegWriteW, writeregW) : FWD_RF;

endmodule
